// File: rtl/fpu_mul_scheduler_pkg.sv
// Shared definitions for the two-requester fixed-point multiply scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_mul_scheduler_pkg;

   // Operand width of the shared external 16x16 multiplier
   localparam int SCH_MUL_W   = 16;
   // Number of requesters sharing the multiplier
   localparam int SCH_NUM_REQ = 2;

   typedef enum logic [1:0] {
      SCH_IDLE = 2'd0,
      SCH_MUL  = 2'd1,
      SCH_DONE = 2'd2
   } sch_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
// Latency: grant is combinational from req; the last-winner register updates on the granting edge.
// Backpressure: no grant while enable is low; a requester must hold req until granted.
module rr_arbiter2
   import fpu_mul_scheduler_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [SCH_NUM_REQ-1:0] req,
   output logic [SCH_NUM_REQ-1:0] grant,
   output logic                   grant_id
);

   // Reset to 1 so that requester 0 wins the first tie
   logic last_grant;

   // One-hot grant: a lone request wins, a tie goes to !last_grant
   always_comb begin
      grant = '0;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign grant_id = grant[1];

   // Remember the winner whenever a grant is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= grant_id;
   end

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Shares one external 16x16 multiplier between two requesters for 32x32 fixed-point multiplies.
// Latency: accept edge t, four partial-product cycles, resp_valid from cycle t+5; one op per 6 cycles at best.
// Backpressure: response held stable until resp_ready; no new request is accepted until the response is taken.
module fpu_mul_scheduler
   import fpu_mul_scheduler_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FBITS = 10,
   parameter int MUL_W = SCH_MUL_W
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [SCH_NUM_REQ-1:0]       req_valid,
   output logic [SCH_NUM_REQ-1:0]       req_ready,
   input  logic [SCH_NUM_REQ*WIDTH-1:0] req_op1,
   input  logic [SCH_NUM_REQ*WIDTH-1:0] req_op2,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic                         resp_id,
   output logic [WIDTH-1:0]             resp_result,
   output logic [MUL_W-1:0]             mul_a,
   output logic [MUL_W-1:0]             mul_b,
   input  logic [2*MUL_W-1:0]           mul_p
);

   sch_state_t           state;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   pp_ext;
   logic [2*WIDTH-1:0]   pp_shifted;
   logic [2*WIDTH-1:0]   acc_next;
   logic [1:0]           step;
   logic                 owner;
   logic [1:0]           grant;
   logic                 grant_id;
   logic                 arb_enable;

   // Grants only in IDLE; reset masks the grant so req_ready drops immediately
   assign arb_enable = (state == SCH_IDLE) && !reset;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .enable   (arb_enable),
      .req      (req_valid),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;

   // Step bit 1 selects the A half, step bit 0 the B half: Al*Bl, Al*Bh, Ah*Bl, Ah*Bh
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state == SCH_MUL) begin
         mul_a = step[1] ? a_q[WIDTH-1:MUL_W] : a_q[MUL_W-1:0];
         mul_b = step[0] ? b_q[WIDTH-1:MUL_W] : b_q[MUL_W-1:0];
      end
   end

   // Align the partial product to its weight and add it into the 64-bit accumulator
   always_comb begin
      pp_ext = {{(2*WIDTH-2*MUL_W){1'b0}}, mul_p};
      case (step)
         2'd0:    pp_shifted = pp_ext;
         2'd3:    pp_shifted = pp_ext << (2*MUL_W);
         default: pp_shifted = pp_ext << MUL_W;
      endcase
      acc_next = acc + pp_shifted;
   end

   // Scheduler FSM with registered response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= SCH_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc         <= '0;
         step        <= '0;
         owner       <= 1'b0;
         resp_valid  <= 1'b0;
         resp_id     <= 1'b0;
         resp_result <= '0;
      end else begin
         case (state)
            SCH_IDLE: begin
               if (|grant) begin
                  a_q   <= grant_id ? req_op1[2*WIDTH-1:WIDTH] : req_op1[WIDTH-1:0];
                  b_q   <= grant_id ? req_op2[2*WIDTH-1:WIDTH] : req_op2[WIDTH-1:0];
                  owner <= grant_id;
                  acc   <= '0;
                  step  <= '0;
                  state <= SCH_MUL;
               end
            end
            SCH_MUL: begin
               acc  <= acc_next;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  // Upper product bits are dropped: no saturation
                  resp_valid  <= 1'b1;
                  resp_id     <= owner;
                  resp_result <= acc_next[WIDTH+FBITS-1:FBITS];
                  state       <= SCH_DONE;
               end
            end
            SCH_DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= SCH_IDLE;
               end
            end
            default: state <= SCH_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Directed self-checking bench for fpu_mul_scheduler with a behavioural 16x16 multiplier.
// Latency: n/a.
// Backpressure: resp_ready is driven by the bench to exercise the DONE hold.
module tb_fpu_mul_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_op1;
   logic [63:0] req_op2;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [31:0] resp_result;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [31:0] mul_p;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // The shared multiplier lives outside the block
   assign mul_p = mul_a * mul_b;

   fpu_mul_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op1     (req_op1),
      .req_op2     (req_op2),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_p       (mul_p)
   );

   // Raise a request on lane id and hold it until granted; returns at the negedge after acceptance
   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, output bit ok);
      ok = 1'b0;
      req_valid[id] = 1'b1;
      req_op1[id*32 +: 32] = a;
      req_op2[id*32 +: 32] = b;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req_ready[id]) begin
            ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_valid[id] = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (!ok) req_valid[id] = 1'b0;
   endtask

   // Count negedges (starting at 1 for the current one) until resp_valid; 0 means timeout
   task automatic wait_resp(output int lat);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         if (resp_valid) begin
            lat = n;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '0;
      req_op1 = '0;
      req_op2 = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      n_cmp++; if (resp_id !== 1'b0) begin n_err++; $display("FAIL reset_resp_id got=%b exp=0", resp_id); end
      n_cmp++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
      n_cmp++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin n_err++; $display("FAIL reset_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_resp_valid got=%b exp=0", resp_valid); end
   endtask

   task automatic test_basic();
      bit ok;
      int lat;
      issue(0, 32'h0000_0600, 32'h0000_0800, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_grant got=none exp=granted"); end
      wait_resp(lat);
      n_cmp++; if (lat != 5) begin n_err++; $display("FAIL basic_latency got=%0d exp=5", lat); end
      n_cmp++; if (resp_id !== 1'b0) begin n_err++; $display("FAIL basic_id got=%b exp=0", resp_id); end
      n_cmp++; if (resp_result !== 32'h0000_0C00) begin n_err++; $display("FAIL basic_result got=%h exp=00000c00", resp_result); end
      ack();
   endtask

   task automatic test_cross_half();
      bit ok;
      int lat;
      logic [15:0] ea;
      logic [15:0] eb;
      issue(1, 32'h0001_0000, 32'h0001_0000, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL cross_grant got=none exp=granted"); end
      for (int s = 0; s < 4; s++) begin
         ea = (s >= 2) ? 16'd1 : 16'd0;
         eb = (s % 2 == 1) ? 16'd1 : 16'd0;
         n_cmp++;
         if (mul_a !== ea || mul_b !== eb) begin
            n_err++; $display("FAIL cross_step%0d_ops got=%h/%h exp=%h/%h", s, mul_a, mul_b, ea, eb);
         end
         @(negedge clk);
      end
      wait_resp(lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL cross_valid_after_steps got=%0d exp=1", lat); end
      n_cmp++; if (resp_id !== 1'b1) begin n_err++; $display("FAIL cross_id got=%b exp=1", resp_id); end
      n_cmp++; if (resp_result !== 32'h0040_0000) begin n_err++; $display("FAIL cross_result got=%h exp=00400000", resp_result); end
      ack();
   endtask

   task automatic test_truncation();
      bit ok;
      int lat;
      issue(0, 32'h8000_0000, 32'h0000_0800, ok);
      wait_resp(lat);
      n_cmp++; if (!ok || lat == 0) begin n_err++; $display("FAIL trunc0_handshake got=ok%0d/lat%0d exp=granted/resp", ok, lat); end
      n_cmp++; if (resp_result !== 32'h0000_0000) begin n_err++; $display("FAIL trunc0_result got=%h exp=00000000", resp_result); end
      ack();
      issue(0, 32'hFFFF_FFFF, 32'h0000_0400, ok);
      wait_resp(lat);
      n_cmp++; if (!ok || lat == 0) begin n_err++; $display("FAIL trunc1_handshake got=ok%0d/lat%0d exp=granted/resp", ok, lat); end
      n_cmp++; if (resp_result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL trunc1_result got=%h exp=ffffffff", resp_result); end
      ack();
   endtask

   task automatic test_arbitration();
      bit got;
      int lat;
      logic       eid;
      logic [1:0] erdy;
      logic [31:0] eres;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req_op1 = {32'h0000_0C00, 32'h0000_0800};
      req_op2 = {32'h0000_0800, 32'h0000_0800};
      req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         eid  = (k == 1);
         erdy = eid ? 2'b10 : 2'b01;
         eres = eid ? 32'h0000_1800 : 32'h0000_1000;
         got  = 1'b0;
         for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++;
            if (req_ready === 2'b11) begin n_err++; $display("FAIL arb_onehot got=%b exp=at_most_one", req_ready); end
            if (|req_ready) begin got = 1'b1; break; end
            @(negedge clk);
         end
         n_cmp++; if (!got || req_ready !== erdy) begin n_err++; $display("FAIL arb_grant%0d got=%b exp=%b", k, req_ready, erdy); end
         @(posedge clk);
         @(negedge clk);
         n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL arb_busy_ready%0d got=%b exp=00", k, req_ready); end
         wait_resp(lat);
         n_cmp++; if (lat != 5) begin n_err++; $display("FAIL arb_latency%0d got=%0d exp=5", k, lat); end
         n_cmp++; if (resp_id !== eid) begin n_err++; $display("FAIL arb_id%0d got=%b exp=%b", k, resp_id, eid); end
         n_cmp++; if (resp_result !== eres) begin n_err++; $display("FAIL arb_result%0d got=%h exp=%h", k, resp_result, eres); end
         ack();
      end
      req_valid = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      issue(0, 32'h0000_1400, 32'h0000_0800, ok);
      req_valid[1] = 1'b1;
      req_op1[63:32] = 32'h0000_0400;
      req_op2[63:32] = 32'h0000_0400;
      wait_resp(lat);
      n_cmp++; if (!ok || lat != 5) begin n_err++; $display("FAIL bp_latency got=ok%0d/lat%0d exp=granted/5", ok, lat); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (resp_valid !== 1'b1 || resp_result !== 32'h0000_2800 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL bp_hold%0d got=v%b/r%h/id%b/rdy%b exp=v1/r00002800/id0/rdy00", i, resp_valid, resp_result, resp_id, req_ready);
         end
         @(negedge clk);
      end
      ack();
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_regrant got=%b exp=10", req_ready); end
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      wait_resp(lat);
      n_cmp++; if (lat != 5 || resp_id !== 1'b1) begin n_err++; $display("FAIL bp_second_resp got=lat%0d/id%b exp=lat5/id1", lat, resp_id); end
      n_cmp++; if (resp_result !== 32'h0000_0400) begin n_err++; $display("FAIL bp_second_result got=%h exp=00000400", resp_result); end
      ack();
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      bit seen;
      int lat;
      issue(0, 32'h1234_5678, 32'h9ABC_DEF0, ok);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (!ok || mul_a !== 16'h1234 || mul_b !== 16'hDEF0) begin n_err++; $display("FAIL rst_step2_ops got=%h/%h exp=1234/def0", mul_a, mul_b); end
      req_valid[1] = 1'b1;
      reset = 1'b1;
      #1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
      n_cmp++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin n_err++; $display("FAIL rst_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); end
      @(negedge clk);
      reset = 1'b0;
      req_valid[1] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (seen) begin n_err++; $display("FAIL rst_no_response got=resp exp=none"); end
      issue(0, 32'h0000_0C00, 32'h0000_1000, ok);
      wait_resp(lat);
      n_cmp++; if (!ok || lat != 5) begin n_err++; $display("FAIL rst_next_latency got=ok%0d/lat%0d exp=granted/5", ok, lat); end
      n_cmp++; if (resp_result !== 32'h0000_3000 || resp_id !== 1'b0) begin n_err++; $display("FAIL rst_next_result got=%h/id%b exp=00003000/id0", resp_result, resp_id); end
      ack();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cross_half();
      test_truncation();
      test_arbitration();
      test_backpressure();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
